// File: rtl/iram_arb_pkg.sv
// iram_arb_pkg: shared types and constants for the two-master iram AXI4-Lite arbiter
// Contents:
//   state_e        - arbiter FSM states
//   M_CORE, M_DBG  - master IDs (grant owner / round-robin pointer encoding)
package iram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_e;

    localparam logic M_CORE = 1'b0;
    localparam logic M_DBG  = 1'b1;

endpackage

// File: rtl/iram_arb_if.sv
// iram_arb_if: AXI4-Lite bundle (AW, W, B, AR, R) used on both sides of the arbiter
// Modports:
//   master - drives AW/W/AR payload+valid and B/R ready (issuer side)
//   slave  - drives AW/W/AR ready and B/R payload+valid (responder side)
interface iram_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/iram_arb_rr_arb2.sv
// rr_arb2: two-way round-robin winner select (combinational)
// Ports:
//   req[1:0] in  - request per master (bit0 = M0, bit1 = M1)
//   last     in  - ID of the master granted most recently
//   gnt[1:0] out - one-hot winner, 0 when nobody requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the master that was not granted last wins.
    always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/iram_arb.sv
// iram_arb: per-transaction round-robin arbiter sharing the iram AXI4-Lite slave
//           between the core LSU (M0) and the debug/ISP loader (M1)
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   m0, m1    - master-facing AXI4-Lite bundles (arbiter is their slave)
//   s         - iram-facing AXI4-Lite bundle (arbiter is its master)
//   grant_o   - one-hot owner (bit0 = M0, bit1 = M1), 0 when idle
module iram_arb
    import iram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    iram_arb_if.slave        m0,
    iram_arb_if.slave        m1,
    iram_arb_if.master       s,
    output logic [1:0]       grant_o
);

    state_e      state_q, state_d;
    logic        own_q, own_d;
    logic        last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  wreq, rreq, gnt;
    logic        own_bready, own_rready;
    logic        in_wa, in_wr, in_ra, in_rd;
    logic [ADDR_W-1:0] own_awaddr, own_araddr;
    logic [DATA_W-1:0] own_wdata;

    assign wreq = {m1.awvalid & m1.wvalid, m0.awvalid & m0.wvalid};
    assign rreq = {m1.arvalid, m0.arvalid};

    rr_arb2 u_rr (
        .req  (wreq | rreq),
        .last (last_q),
        .gnt  (gnt)
    );

    assign own_bready = own_q ? m1.bready : m0.bready;
    assign own_rready = own_q ? m1.rready : m0.rready;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: if (|gnt) begin
                own_d   = gnt[1];
                // A winner with a write and a read pending is served the write first.
                state_d = (gnt[1] ? wreq[1] : wreq[0]) ? WADDR : RADDR;
            end
            WADDR: if (s.awready & s.wready) state_d = WRESP;
            WRESP: if (s.bvalid & own_bready) begin
                state_d = IDLE;
                last_d  = own_q;
            end
            RADDR: if (s.arready) state_d = RDATA;
            RDATA: if (s.rvalid & own_rready) begin
                state_d = IDLE;
                last_d  = own_q;
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == IDLE) ? 2'b00 : (own_d ? 2'b10 : 2'b01);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= M_CORE;
            last_q  <= M_DBG;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign grant_o = grant_q;

    assign in_wa = (state_q == WADDR);
    assign in_wr = (state_q == WRESP);
    assign in_ra = (state_q == RADDR);
    assign in_rd = (state_q == RDATA);

    assign own_awaddr = own_q ? m1.awaddr : m0.awaddr;
    assign own_araddr = own_q ? m1.araddr : m0.araddr;
    assign own_wdata  = own_q ? m1.wdata  : m0.wdata;

    // Toward iram: only the owner's channel in the matching state, zero otherwise.
    assign s.awaddr  = in_wa ? own_awaddr : '0;
    assign s.awprot  = in_wa ? (own_q ? m1.awprot : m0.awprot) : '0;
    assign s.awvalid = in_wa & (own_q ? m1.awvalid : m0.awvalid);
    assign s.wdata   = in_wa ? own_wdata : '0;
    assign s.wstrb   = in_wa ? (own_q ? m1.wstrb : m0.wstrb) : '0;
    assign s.wvalid  = in_wa & (own_q ? m1.wvalid : m0.wvalid);
    assign s.bready  = in_wr & own_bready;
    assign s.araddr  = in_ra ? own_araddr : '0;
    assign s.arprot  = in_ra ? (own_q ? m1.arprot : m0.arprot) : '0;
    assign s.arvalid = in_ra & (own_q ? m1.arvalid : m0.arvalid);
    assign s.rready  = in_rd & own_rready;

    // Toward masters: a slave bvalid outside WRESP (iram holds B high) never leaks.
    assign m0.awready = in_wa & ~own_q & s.awready;
    assign m0.wready  = in_wa & ~own_q & s.wready;
    assign m0.bvalid  = in_wr & ~own_q & s.bvalid;
    assign m0.bresp   = (in_wr & ~own_q) ? s.bresp : '0;
    assign m0.arready = in_ra & ~own_q & s.arready;
    assign m0.rvalid  = in_rd & ~own_q & s.rvalid;
    assign m0.rdata   = (in_rd & ~own_q) ? s.rdata : '0;
    assign m0.rresp   = (in_rd & ~own_q) ? s.rresp : '0;

    assign m1.awready = in_wa & own_q & s.awready;
    assign m1.wready  = in_wa & own_q & s.wready;
    assign m1.bvalid  = in_wr & own_q & s.bvalid;
    assign m1.bresp   = (in_wr & own_q) ? s.bresp : '0;
    assign m1.arready = in_ra & own_q & s.arready;
    assign m1.rvalid  = in_rd & own_q & s.rvalid;
    assign m1.rdata   = (in_rd & own_q) ? s.rdata : '0;
    assign m1.rresp   = (in_rd & own_q) ? s.rresp : '0;

endmodule

// File: tb/tb_iram_arb.sv
// tb_iram_arb: directed bench for iram_arb with a small iram-like slave model
`timescale 1ns/1ps
module tb_iram_arb;

    logic clk, rst;
    logic [1:0] grant;
    int passed = 0;
    int total  = 0;

    iram_arb_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    iram_arb_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    iram_arb_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    iram_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant_o (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // iram model: always-ready address/data, B/R one cycle after the handshake,
    // read data = address + 0x1000_0000 so each master's data is distinguishable.
    logic        bpend, rpend, bforce;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bpend   <= 1'b0;
            rpend   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (s_if.awvalid & s_if.awready & s_if.wvalid & s_if.wready) bpend <= 1'b1;
            else if (s_if.bvalid & s_if.bready) bpend <= 1'b0;
            if (s_if.arvalid & s_if.arready) begin
                rpend   <= 1'b1;
                rdata_q <= s_if.araddr + 32'h1000_0000;
            end else if (s_if.rvalid & s_if.rready) rpend <= 1'b0;
        end
    end

    assign s_if.awready = 1'b1;
    assign s_if.wready  = 1'b1;
    assign s_if.arready = 1'b1;
    assign s_if.bvalid  = bpend | bforce;
    assign s_if.bresp   = 2'b00;
    assign s_if.rvalid  = rpend;
    assign s_if.rdata   = rdata_q;
    assign s_if.rresp   = 2'b00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        bforce = 1'b0;
        m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.awvalid = 0; m0_if.wdata = '0;
        m0_if.wstrb = 4'hf; m0_if.wvalid = 0; m0_if.bready = 1; m0_if.araddr = '0;
        m0_if.arprot = '0; m0_if.arvalid = 0; m0_if.rready = 1;
        m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.awvalid = 0; m1_if.wdata = '0;
        m1_if.wstrb = 4'hf; m1_if.wvalid = 0; m1_if.bready = 1; m1_if.araddr = '0;
        m1_if.arprot = '0; m1_if.arvalid = 0; m1_if.rready = 1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_awvalid", s_if.awvalid, 0);
        chk("rst_s_arvalid", s_if.arvalid, 0);
        chk("rst_s_bready", s_if.bready, 0);
        chk("rst_m0_awready", m0_if.awready, 0);
        chk("rst_m1_arready", m1_if.arready, 0);

        // M0 single write
        m0_if.awaddr = 32'h0000_0010; m0_if.wdata = 32'hDEAD_BEEF;
        m0_if.awvalid = 1; m0_if.wvalid = 1;
        #1;
        chk("w0_idle_s_awvalid", s_if.awvalid, 0);
        chk("w0_idle_grant", grant, 2'b00);
        tick();
        chk("w0_grant_n1", grant, 2'b01);
        chk("w0_s_awvalid", s_if.awvalid, 1);
        chk("w0_s_awaddr", s_if.awaddr, 32'h0000_0010);
        chk("w0_s_wdata", s_if.wdata, 32'hDEAD_BEEF);
        chk("w0_m0_awready", m0_if.awready, 1);
        chk("w0_m1_awready", m1_if.awready, 0);
        tick();
        m0_if.awvalid = 0; m0_if.wvalid = 0;
        chk("w0_grant_n2", grant, 2'b01);
        chk("w0_m0_bvalid", m0_if.bvalid, 1);
        chk("w0_m0_bresp", m0_if.bresp, 2'b00);
        chk("w0_m1_bvalid", m1_if.bvalid, 0);
        tick();
        chk("w0_grant_n3", grant, 2'b00);
        chk("w0_m0_bvalid_done", m0_if.bvalid, 0);

        // Simultaneous reads right after reset: M0 first, then M1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_if.araddr = 32'h100; m0_if.arvalid = 1;
        m1_if.araddr = 32'h200; m1_if.arvalid = 1;
        tick();
        chk("rr1_grant", grant, 2'b01);
        chk("rr1_s_araddr", s_if.araddr, 32'h100);
        chk("rr1_m0_arready", m0_if.arready, 1);
        chk("rr1_m1_arready", m1_if.arready, 0);
        tick();
        m0_if.arvalid = 0;
        chk("rr1_m0_rvalid", m0_if.rvalid, 1);
        chk("rr1_m0_rdata", m0_if.rdata, 32'h1000_0100);
        chk("rr1_m1_rvalid", m1_if.rvalid, 0);
        chk("rr1_m1_rdata", m1_if.rdata, 32'h0);
        tick();
        chk("rr1_idle", grant, 2'b00);
        tick();
        chk("rr2_grant", grant, 2'b10);
        chk("rr2_s_araddr", s_if.araddr, 32'h200);
        tick();
        m1_if.arvalid = 0;
        chk("rr2_m1_rdata", m1_if.rdata, 32'h1000_0200);
        chk("rr2_m0_rvalid", m0_if.rvalid, 0);
        tick();
        m0_if.araddr = 32'h300; m0_if.arvalid = 1;
        m1_if.araddr = 32'h400; m1_if.arvalid = 1;
        tick();
        chk("rr3_grant_m0_again", grant, 2'b01);
        chk("rr3_s_araddr", s_if.araddr, 32'h300);
        tick();
        m0_if.arvalid = 0;
        chk("rr3_m0_rdata", m0_if.rdata, 32'h1000_0300);
        tick();
        tick();
        chk("rr4_grant", grant, 2'b10);
        tick();
        m1_if.arvalid = 0;
        chk("rr4_m1_rdata", m1_if.rdata, 32'h1000_0400);
        tick();
        chk("rr4_idle", grant, 2'b00);

        // M1 write and read together: write first
        m1_if.awaddr = 32'h0800_0004; m1_if.wdata = 32'hCAFE_0001;
        m1_if.araddr = 32'h0800_0004;
        m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.arvalid = 1;
        tick();
        chk("wr_grant", grant, 2'b10);
        chk("wr_s_awaddr", s_if.awaddr, 32'h0800_0004);
        chk("wr_s_arvalid", s_if.arvalid, 0);
        chk("wr_m1_arready_wa", m1_if.arready, 0);
        tick();
        m1_if.awvalid = 0; m1_if.wvalid = 0;
        chk("wr_m1_bvalid", m1_if.bvalid, 1);
        chk("wr_m1_arready_wr", m1_if.arready, 0);
        tick();
        chk("wr_idle", grant, 2'b00);
        chk("wr_m1_arready_idle", m1_if.arready, 0);
        tick();
        chk("wr_rd_grant", grant, 2'b10);
        chk("wr_m1_arready_ra", m1_if.arready, 1);
        chk("wr_s_araddr", s_if.araddr, 32'h0800_0004);
        tick();
        m1_if.arvalid = 0;
        chk("wr_m1_rdata", m1_if.rdata, 32'h1800_0004);
        tick();
        chk("wr_done", grant, 2'b00);

        // M1 stalls R for 5 cycles while M0 wants to write
        m1_if.araddr = 32'h20; m1_if.arvalid = 1; m1_if.rready = 0;
        tick();
        tick();
        m1_if.arvalid = 0;
        m0_if.awaddr = 32'h40; m0_if.wdata = 32'h1234; m0_if.awvalid = 1; m0_if.wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("st_m0_awready", m0_if.awready, 0);
            chk("st_grant", grant, 2'b10);
            tick();
        end
        chk("st_m1_rvalid", m1_if.rvalid, 1);
        chk("st_m1_rdata", m1_if.rdata, 32'h1000_0020);
        m1_if.rready = 1;
        tick();
        chk("st_idle", grant, 2'b00);
        chk("st_m0_awready_idle", m0_if.awready, 0);
        tick();
        chk("st_m0_grant", grant, 2'b01);
        chk("st_m0_awready", m0_if.awready, 1);
        chk("st_s_awaddr", s_if.awaddr, 32'h40);
        tick();
        m0_if.awvalid = 0; m0_if.wvalid = 0;
        chk("st_m0_bvalid", m0_if.bvalid, 1);
        tick();

        // Reset pulsed in WRESP
        m0_if.awaddr = 32'h50; m0_if.wdata = 32'h55; m0_if.awvalid = 1; m0_if.wvalid = 1;
        tick();
        tick();
        m0_if.awvalid = 0; m0_if.wvalid = 0;
        chk("rw_m0_bvalid", m0_if.bvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_grant", grant, 2'b00);
        chk("rw_m0_bvalid", m0_if.bvalid, 0);
        chk("rw_s_bready", s_if.bready, 0);
        chk("rw_s_awvalid", s_if.awvalid, 0);
        m1_if.awaddr = 32'h60; m1_if.wdata = 32'h66; m1_if.awvalid = 1; m1_if.wvalid = 1;
        tick();
        chk("rw_m1_grant", grant, 2'b10);
        chk("rw_s_awaddr", s_if.awaddr, 32'h60);
        chk("rw_m1_awready", m1_if.awready, 1);
        tick();
        m1_if.awvalid = 0; m1_if.wvalid = 0;
        chk("rw_m1_bvalid", m1_if.bvalid, 1);
        tick();
        chk("rw_idle", grant, 2'b00);

        // Slave B stuck high while idle never reaches a master
        bforce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bf_m0_bvalid", m0_if.bvalid, 0);
            chk("bf_m1_bvalid", m1_if.bvalid, 0);
            chk("bf_s_bready", s_if.bready, 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
